// File: rtl/sd_pkg.sv
// Shared types and constants for the SD 4-bit data-block receiver.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    END_BIT,
    DONE
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [3:0]  START_BITS = 4'b0000;
  localparam logic [3:0]  END_BITS   = 4'b1111;

  // One serial CRC16 step: shift left, fold the polynomial in when the
  // outgoing MSB differs from the incoming bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/m_crc16_serial.sv
// Bit-serial CRC16 (poly 0x1021, init 0) for a single SD DAT line.
module m_crc16_serial
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  // NOTE: sequential state is assigned with <= so every register sees
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= crc16_step(crc, bit_in);
  end

endmodule

// File: rtl/m_sd_block_receiver.sv
// Receives one SD 4-bit data block, packs bytes into 32-bit buffer writes
// and checks the per-line CRC16 and end bit.
module m_sd_block_receiver
  import sd_pkg::*;
#(
  parameter int ADDR_LEN        = 9,
  parameter int BLOCK_BYTES     = 512,
  parameter int TIMEOUT_STROBES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sd_clk_en,
  input  logic [3:0]        dat_in,
  input  logic              start,
  input  logic [ADDR_LEN:0] base_addr,
  output logic              buf_we,
  output logic [ADDR_LEN:0] buf_write_addr,
  output logic [31:0]       buf_write_data,
  output logic              busy,
  output logic              done,
  output logic              crc_err,
  output logic              timeout_err
);

  localparam int NIBBLES = BLOCK_BYTES * 2;
  localparam int NW      = $clog2(NIBBLES);
  localparam int TW      = $clog2(TIMEOUT_STROBES + 1);

  localparam logic [NW-1:0]     LAST_NIBBLE = NW'(NIBBLES - 1);
  localparam logic [TW-1:0]     LAST_WAIT   = TW'(TIMEOUT_STROBES - 1);
  localparam logic [ADDR_LEN:0] WORD_STEP   = (ADDR_LEN + 1)'(4);

  state_t            state;
  logic [NW-1:0]     nib_cnt;
  logic [3:0]        bit_cnt;
  logic [TW-1:0]     to_cnt;
  logic [31:0]       word;
  logic [31:0]       word_next;
  logic [ADDR_LEN:0] word_addr;
  logic              crc_bad;
  logic [15:0]       crc_val [4];
  logic [3:0]        crc_bit;
  logic              accept;
  logic              data_en;

  assign accept  = (state == IDLE) && start;
  assign data_en = (state == DATA) && sd_clk_en;

  for (genvar l = 0; l < 4; l++) begin : g_crc
    m_crc16_serial u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .en     (data_en),
      .bit_in (dat_in[l]),
      .crc    (crc_val[l])
    );
  end

  // First nibble of a byte lands in [7:4]; byte k of the word in [8k+7:8k].
  always_comb begin
    word_next = word;
    word_next[{nib_cnt[2:1], ~nib_cnt[0], 2'b00} +: 4] = dat_in;
  end

  // Received CRC arrives MSB first, so bit_cnt i selects crc bit 15-i.
  always_comb begin
    crc_bit = '0;
    for (int l = 0; l < 4; l++) crc_bit[l] = crc_val[l][~bit_cnt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      nib_cnt        <= '0;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      word           <= '0;
      word_addr      <= '0;
      crc_bad        <= 1'b0;
      buf_we         <= 1'b0;
      buf_write_addr <= '0;
      buf_write_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      crc_err        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle, so a single assignment
      // below yields exactly a one-clk pulse.
      buf_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= WAIT_START;
            busy        <= 1'b1;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
            word_addr   <= base_addr;
            nib_cnt     <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            crc_bad     <= 1'b0;
          end
        end
        WAIT_START: begin
          if (sd_clk_en) begin
            if (dat_in == START_BITS) begin
              state <= DATA;
            end else if (to_cnt == LAST_WAIT) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sd_clk_en) begin
            word    <= word_next;
            nib_cnt <= nib_cnt + 1'b1;
            if (nib_cnt[2:0] == 3'd7) begin
              buf_we         <= 1'b1;
              buf_write_data <= word_next;
              buf_write_addr <= word_addr;
              word_addr      <= word_addr + WORD_STEP;
            end
            if (nib_cnt == LAST_NIBBLE) state <= CRC;
          end
        end
        CRC: begin
          if (sd_clk_en) begin
            if (dat_in != crc_bit) crc_bad <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd15) state <= END_BIT;
          end
        end
        END_BIT: begin
          if (sd_clk_en) begin
            crc_err <= crc_bad || (dat_in != END_BITS);
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_sd_block_receiver.sv
// Directed bench for m_sd_block_receiver: full blocks, CRC/end-bit errors,
// address wrap, timeout, mid-block reset and ignored start pulses.
module tb_m_sd_block_receiver;

  localparam int AL = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sd_clk_en = 1'b0;
  logic [3:0]    dat_in = 4'hF;
  logic          start = 1'b0;
  logic          start_to = 1'b0;
  logic [AL:0]   base_addr = '0;

  logic          buf_we, busy, done, crc_err, timeout_err;
  logic [AL:0]   buf_write_addr;
  logic [31:0]   buf_write_data;
  logic          buf_we_to, busy_to, done_to, crc_err_to, timeout_err_to;
  logic [AL:0]   buf_write_addr_to;
  logic [31:0]   buf_write_data_to;

  m_sd_block_receiver #(.ADDR_LEN(AL)) dut (
    .clk(clk), .rst_n(rst_n), .sd_clk_en(sd_clk_en), .dat_in(dat_in),
    .start(start), .base_addr(base_addr), .buf_we(buf_we),
    .buf_write_addr(buf_write_addr), .buf_write_data(buf_write_data),
    .busy(busy), .done(done), .crc_err(crc_err), .timeout_err(timeout_err)
  );

  m_sd_block_receiver #(.ADDR_LEN(AL), .TIMEOUT_STROBES(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .sd_clk_en(sd_clk_en), .dat_in(dat_in),
    .start(start_to), .base_addr(base_addr), .buf_we(buf_we_to),
    .buf_write_addr(buf_write_addr_to), .buf_write_data(buf_write_data_to),
    .busy(busy_to), .done(done_to), .crc_err(crc_err_to), .timeout_err(timeout_err_to)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [AL:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          done_cnt = 0;
  int          done_to_cnt = 0;
  int          we_double = 0;
  logic        prev_we = 1'b0;
  logic [15:0] exp_crc [4];
  int          mid_start_at = -1;

  always @(negedge clk) begin
    if (buf_we) begin
      wr_addr.push_back(buf_write_addr);
      wr_data.push_back(buf_write_data);
    end
    if (buf_we && prev_we) we_double++;
    prev_we = buf_we;
    if (done)    done_cnt++;
    if (done_to) done_to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload byte i is i mod 256, sent high nibble first.
  function automatic logic [3:0] nib(input int i);
    logic [7:0] b;
    b = 8'((i / 2) % 256);
    return (i % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  function automatic logic [15:0] calc_crc(input int line);
    logic [15:0] c;
    logic [3:0]  n;
    logic        top;
    c = '0;
    for (int i = 0; i < 1024; i++) begin
      n   = nib(i);
      top = c[15] ^ n[line];
      c   = c << 1;
      if (top) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [31:0] exp_word(input int j);
    return {8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1), 8'(4*j)};
  endfunction

  function automatic logic [31:0] got_addr(input int j);
    return (j < wr_addr.size()) ? 32'(wr_addr[j]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] got_data(input int j);
    return (j < wr_data.size()) ? wr_data[j] : 32'hDEAD_BEEF;
  endfunction

  // Called at posedge+1; returns at posedge+1 three clocks later.
  task automatic strobe(input logic [3:0] d);
    dat_in = d;
    sd_clk_en = 1'b1;
    @(posedge clk); #1;
    sd_clk_en = 1'b0;
    dat_in = 4'hF;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AL:0] a);
    base_addr = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_data(input int n);
    strobe(4'hF);
    strobe(4'hF);
    strobe(4'h0);
    for (int i = 0; i < n; i++) begin
      if (i == mid_start_at) pulse_start(10'h155);
      strobe(nib(i));
    end
  endtask

  task automatic send_tail(input int flip_line, input int flip_bit, input logic [3:0] end_val);
    logic [15:0] c [4];
    for (int l = 0; l < 4; l++) c[l] = exp_crc[l];
    if (flip_line >= 0) c[flip_line][flip_bit] = ~c[flip_line][flip_bit];
    for (int i = 15; i >= 0; i--) strobe({c[3][i], c[2][i], c[1][i], c[0][i]});
    strobe(end_val);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    we_double = 0;
  endtask

  task automatic check_block(input string tag, input logic [AL:0] base, input logic exp_err);
    logic ok;
    logic [AL:0] ea;
    ok = 1'b1;
    check({tag, "_writes"}, wr_addr.size(), 128);
    for (int j = 0; j < wr_addr.size(); j++) begin
      ea = (AL+1)'(int'(base) + 4*j);
      if (wr_addr[j] !== ea || wr_data[j] !== exp_word(j)) ok = 1'b0;
    end
    check({tag, "_all_words"}, ok, 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_crc_err"}, crc_err, exp_err);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_we_one_clk"}, we_double, 0);
  endtask

  initial begin
    for (int l = 0; l < 4; l++) exp_crc[l] = calc_crc(l);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", buf_we, 0);
    check("rst_crc_err", crc_err, 0);
    check("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good block, base 0
    clear_log();
    pulse_start(10'd0);
    check("b1_busy_on_start", busy, 1);
    send_data(1024);
    send_tail(-1, 0, 4'hF);
    check_block("b1", 10'd0, 1'b0);
    check("b1_first_addr", got_addr(0), 32'd0);
    check("b1_first_data", got_data(0), 32'h03020100);
    check("b1_last_addr", got_addr(127), 32'd508);
    check("b1_last_data", got_data(127), 32'hFFFEFDFC);

    // CRC bit 5 of DAT2 flipped: writes still happen, crc_err set
    clear_log();
    pulse_start(10'd0);
    send_data(1024);
    send_tail(2, 5, 4'hF);
    check_block("crcflip", 10'd0, 1'b1);

    // Next start clears crc_err; bad end bit alone flags an error
    clear_log();
    pulse_start(10'd0);
    check("start_clears_crc_err", crc_err, 0);
    send_data(1024);
    send_tail(-1, 0, 4'hE);
    check_block("endbit", 10'd0, 1'b1);

    // Start pulsed mid-DATA is ignored
    clear_log();
    mid_start_at = 200;
    pulse_start(10'd0);
    send_data(1024);
    send_tail(-1, 0, 4'hF);
    mid_start_at = -1;
    check_block("midstart", 10'd0, 1'b0);
    check("midstart_addr40", got_addr(40), 32'd160);

    // Address wrap from 1020
    clear_log();
    pulse_start(10'd1020);
    send_data(1024);
    send_tail(-1, 0, 4'hF);
    check_block("wrap", 10'd1020, 1'b0);
    check("wrap_first_addr", got_addr(0), 32'd1020);
    check("wrap_second_addr", got_addr(1), 32'd0);
    check("wrap_last_addr", got_addr(127), 32'd504);

    // Timeout after 16 strobes without a start bit
    start_to = 1'b1;
    @(posedge clk); #1;
    start_to = 1'b0;
    for (int i = 0; i < 15; i++) strobe(4'hF);
    check("to_busy_15", busy_to, 1);
    check("to_err_15", timeout_err_to, 0);
    strobe(4'hF);
    check("to_err_16", timeout_err_to, 1);
    check("to_busy_16", busy_to, 0);
    check("to_no_done", done_to_cnt, 0);
    start_to = 1'b1;
    @(posedge clk); #1;
    start_to = 1'b0;
    check("to_cleared_by_start", timeout_err_to, 0);

    // Reset asserted right as word 40 is written
    clear_log();
    pulse_start(10'd0);
    send_data(319);
    dat_in = nib(319);
    sd_clk_en = 1'b1;
    @(posedge clk); #1;
    sd_clk_en = 1'b0;
    dat_in = 4'hF;
    check("mid_we_high", buf_we, 1);
    check("mid_words_before", wr_addr.size(), 39);
    check("mid_word40_data", buf_write_data, exp_word(39));
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", buf_we, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) strobe(4'h0);
    for (int i = 0; i < 12; i++) strobe(4'h5);
    check("post_rst_no_we", wr_addr.size(), 0);
    check("post_rst_idle", busy, 0);
    pulse_start(10'd0);
    send_data(1024);
    send_tail(-1, 0, 4'hF);
    check_block("after_rst", 10'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
